exc_ctrl: RTL and testbench

Exception/interrupt sequencer for the 5-stage MIPS pipeline. Arbitrates between the timer IRQ from the peripheral block and the illegal-opcode flag from decode. Picks the correct restart address (EPC), flushes the front of the pipeline and redirects fetch to the kernel vector. Tracks kernel mode until `eret`, replacing the ad-hoc edge-triggered PC capture with one clocked controller.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/exc_ctrl.sv | 113 +++++++++++
 tb/tb_exc_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: exception vectors, cause encodings and the
// exception-sequencer state type.
package cpu_pkg;

   localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
   localparam logic [31:0] XADR_VEC  = 32'h8000_0008;

   localparam logic [1:0] CAUSE_NONE  = 2'b00;
   localparam logic [1:0] CAUSE_IRQ   = 2'b01;
   localparam logic [1:0] CAUSE_ILLOP = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ENTER  = 2'd1,
      ST_KERNEL = 2'd2
   } exc_state_t;

endpackage

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: arbitrates timer IRQ against illegal opcode,
// captures EPC, flushes IF/ID and redirects fetch; tracks kernel mode until eret.
module exc_ctrl #(
   parameter logic [31:0] ILLOP_VEC = cpu_pkg::ILLOP_VEC,
   parameter logic [31:0] XADR_VEC  = cpu_pkg::XADR_VEC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        irq_req,
   input  logic        illop_id,
   input  logic        eret_id,
   input  logic        stall,
   input  logic        valid_id,
   input  logic [31:0] pc_if,
   input  logic [31:0] pc_id,
   input  logic        redirect_ex,
   input  logic [31:0] target_ex,
   output logic        flush_if,
   output logic        flush_id,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic [31:0] epc,
   output logic        epc_we,
   output logic [1:0]  cause,
   output logic        in_kernel,
   output logic        irq_ack
);
   import cpu_pkg::*;

   exc_state_t  state_q, state_d;
   logic [31:0] vec_q;
   logic [31:0] epc_q;
   logic [1:0]  cause_q;
   logic        kern_q;
   logic        epc_upd_q;
   logic        take_illop, take_irq, leave_kernel;

   // Oldest instruction that has neither retired nor executed.
   function automatic logic [31:0] irq_epc(input logic        rdr,
                                           input logic [31:0] tgt,
                                           input logic        vld,
                                           input logic [31:0] pid,
                                           input logic [31:0] pif);
      if (rdr)      return tgt;
      else if (vld) return pid;
      else          return pif;
   endfunction

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      state_d      = state_q;
      take_illop   = 1'b0;
      take_irq     = 1'b0;
      leave_kernel = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A user-mode eret is itself an illegal instruction.
            if (!stall) begin
               if (illop_id || eret_id)      take_illop = 1'b1;
               else if (irq_req && !kern_q)  take_irq   = 1'b1;
            end
         end
         ST_KERNEL: begin
            // eret wins: a same-cycle illop is squashed by the eret redirect.
            if (!stall) begin
               if (eret_id)       leave_kernel = 1'b1;
               else if (illop_id) take_illop   = 1'b1;
            end
         end
         ST_ENTER: state_d = ST_KERNEL;
         default:  state_d = ST_KERNEL;
      endcase
      if (take_illop || take_irq) state_d = ST_ENTER;
      else if (leave_kernel)      state_d = ST_IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_KERNEL;
         kern_q    <= 1'b1;
         vec_q     <= '0;
         epc_q     <= '0;
         cause_q   <= CAUSE_NONE;
         epc_upd_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (take_illop || take_irq) begin
            vec_q     <= take_illop ? ILLOP_VEC : XADR_VEC;
            cause_q   <= take_illop ? CAUSE_ILLOP : CAUSE_IRQ;
            // A nested fault keeps the user restart point.
            epc_upd_q <= !kern_q;
            if (!kern_q)
               epc_q <= take_illop ? pc_id
                                   : irq_epc(redirect_ex, target_ex, valid_id, pc_id, pc_if);
         end
         if (state_q == ST_ENTER) kern_q <= 1'b1;
         else if (leave_kernel)   kern_q <= 1'b0;
      end
   end

   // Strobes decode from state so an asynchronous reset drops them at once.
   assign redirect    = (state_q == ST_ENTER);
   assign flush_if    = redirect;
   assign flush_id    = redirect;
   assign redirect_pc = vec_q;
   assign epc_we      = redirect && epc_upd_q;
   assign irq_ack     = redirect && (cause_q == CAUSE_IRQ);
   assign epc         = epc_q;
   assign cause       = cause_q;
   assign in_kernel   = kern_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed test-plan steps followed by
// randomized traffic against a behavioural model of the exception rules.
module tb_exc_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        irq_req, illop_id, eret_id, stall, valid_id, redirect_ex;
   logic [31:0] pc_if, pc_id, target_ex;
   logic        flush_if, flush_id, redirect, epc_we, in_kernel, irq_ack;
   logic [31:0] redirect_pc, epc;
   logic [1:0]  cause;

   int checks   = 0;
   int failures = 0;

   // Behavioural model: privilege mode, an entry in progress and saved context.
   bit          m_kern;
   bit          m_entering;
   logic [31:0] m_vec;
   logic [1:0]  m_cause;
   logic [31:0] m_epc;
   bit          m_we;
   bit          prev_pulse;

   exc_ctrl dut (
      .clk(clk), .reset(reset), .irq_req(irq_req), .illop_id(illop_id),
      .eret_id(eret_id), .stall(stall), .valid_id(valid_id), .pc_if(pc_if),
      .pc_id(pc_id), .redirect_ex(redirect_ex), .target_ex(target_ex),
      .flush_if(flush_if), .flush_id(flush_id), .redirect(redirect),
      .redirect_pc(redirect_pc), .epc(epc), .epc_we(epc_we), .cause(cause),
      .in_kernel(in_kernel), .irq_ack(irq_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_kern = 1; m_entering = 0; m_vec = 32'h0; m_cause = 2'b00;
      m_epc = 32'h0; m_we = 0; prev_pulse = 0;
   endtask

   task automatic clear_inputs();
      irq_req = 0; illop_id = 0; eret_id = 0; stall = 0; valid_id = 0;
      redirect_ex = 0; pc_if = 32'h0; pc_id = 32'h0; target_ex = 32'h0;
   endtask

   // Next model state from the current inputs, as seen at the coming clock edge.
   task automatic model_step();
      if (m_entering) begin
         m_entering = 0;
         m_kern     = 1;
      end else if (!stall) begin
         if (m_kern) begin
            if (eret_id) m_kern = 0;
            else if (illop_id) begin
               m_entering = 1; m_vec = 32'h8000_0004; m_cause = 2'b10; m_we = 0;
            end
         end else begin
            if (illop_id || eret_id) begin
               m_entering = 1; m_vec = 32'h8000_0004; m_cause = 2'b10;
               m_we = 1; m_epc = pc_id;
            end else if (irq_req) begin
               m_entering = 1; m_vec = 32'h8000_0008; m_cause = 2'b01; m_we = 1;
               if (redirect_ex)   m_epc = target_ex;
               else if (valid_id) m_epc = pc_id;
               else               m_epc = pc_if;
            end
         end
      end
   endtask

   task automatic compare_all();
      check("redirect",  32'(redirect),  32'(m_entering));
      check("flush_if",  32'(flush_if),  32'(m_entering));
      check("flush_id",  32'(flush_id),  32'(m_entering));
      check("epc_we",    32'(epc_we),    32'(m_entering && m_we));
      check("irq_ack",   32'(irq_ack),   32'(m_entering && m_cause == 2'b01));
      check("in_kernel", 32'(in_kernel), 32'(m_kern));
      check("cause",     32'(cause),     32'(m_cause));
      check("epc",       epc,            m_epc);
      if (m_entering) check("redirect_pc", redirect_pc, m_vec);
      // Single-cycle pulses never repeat in back-to-back cycles.
      if (prev_pulse) check("pulse_gap", 32'(redirect || epc_we || irq_ack), 32'd0);
      prev_pulse = redirect || epc_we || irq_ack;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   // Asynchronous reset pulse between clock edges.
   task automatic async_reset();
      reset = 1'b1;
      #1;
      model_reset();
      check("rst_redirect", 32'(redirect), 32'd0);
      check("rst_epc",      epc,           32'h0);
      check("rst_kernel",   32'(in_kernel), 32'd1);
      check("rst_cause",    32'(cause),     32'd0);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      clear_inputs();
      model_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state.
      check("reset_kernel", 32'(in_kernel), 32'd1);
      check("reset_cause",  32'(cause),     32'd0);
      check("reset_epc",    epc,            32'h0);
      check("reset_strobe", 32'(redirect || epc_we || irq_ack || flush_if || flush_id), 32'd0);

      // eret from boot kernel drops to user mode without a redirect.
      eret_id = 1; tick(); eret_id = 0;
      check("eret_user", 32'(in_kernel), 32'd0);
      check("eret_no_redirect", 32'(redirect), 32'd0);

      // IRQ with a valid ID instruction.
      irq_req = 1; valid_id = 1; pc_id = 32'h40; tick();
      check("irq_redirect", 32'(redirect), 32'd1);
      check("irq_vec",      redirect_pc,   32'h8000_0008);
      check("irq_epc",      epc,           32'h40);
      check("irq_cause",    32'(cause),    32'd1);
      check("irq_ack",      32'(irq_ack),  32'd1);
      check("irq_epc_we",   32'(epc_we),   32'd1);
      clear_inputs(); tick();
      eret_id = 1; tick(); eret_id = 0;

      // IRQ while EX redirects: restart at the branch target.
      irq_req = 1; valid_id = 1; pc_id = 32'h44; redirect_ex = 1; target_ex = 32'h100; tick();
      check("irq_br_epc", epc, 32'h100);
      clear_inputs(); tick();
      eret_id = 1; tick(); eret_id = 0;

      // Illegal opcode beats a simultaneous IRQ.
      illop_id = 1; irq_req = 1; valid_id = 1; pc_id = 32'h20; tick();
      check("ill_vec",   redirect_pc,  32'h8000_0004);
      check("ill_cause", 32'(cause),   32'd2);
      check("ill_epc",   epc,          32'h20);
      check("ill_ack",   32'(irq_ack), 32'd0);
      clear_inputs(); tick();
      eret_id = 1; tick(); eret_id = 0;

      // Stall defers the IRQ; taken on the first unstalled cycle.
      irq_req = 1; valid_id = 1; pc_id = 32'h44; stall = 1;
      tick(); check("stall_hold1", 32'(redirect), 32'd0);
      tick(); check("stall_hold2", 32'(redirect), 32'd0);
      stall = 0; tick(); check("stall_release", 32'(redirect), 32'd1);
      clear_inputs(); tick();

      // Kernel: IRQ masked; nested illop keeps the user EPC.
      irq_req = 1; tick(); check("kern_irq_masked", 32'(redirect), 32'd0);
      irq_req = 0; illop_id = 1; pc_id = 32'h8000_0010; tick();
      check("nest_redirect", 32'(redirect), 32'd1);
      check("nest_vec",      redirect_pc,   32'h8000_0004);
      check("nest_epc",      epc,           32'h44);
      check("nest_epc_we",   32'(epc_we),   32'd0);
      clear_inputs(); tick();

      // eret beats a simultaneous illop in kernel.
      eret_id = 1; illop_id = 1; tick(); clear_inputs();
      check("eret_prio_redirect", 32'(redirect), 32'd0);
      check("eret_prio_user",     32'(in_kernel), 32'd0);

      // Reset during ENTER.
      irq_req = 1; valid_id = 1; pc_id = 32'h88; tick(); clear_inputs();
      check("pre_rst_enter", 32'(redirect), 32'd1);
      async_reset();

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         irq_req     = ($urandom_range(0, 99) < 40);
         illop_id    = ($urandom_range(0, 99) < 8);
         eret_id     = ($urandom_range(0, 99) < 15);
         stall       = ($urandom_range(0, 99) < 25);
         valid_id    = ($urandom_range(0, 99) < 70);
         redirect_ex = ($urandom_range(0, 99) < 20);
         pc_if       = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
         pc_id       = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
         target_ex   = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
         tick();
         if ($urandom_range(0, 299) == 0) async_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
